// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle RISC-V control FSM with memory watchdog.
// Define CTRL_PERF_CNT_EN to add cycle_cnt/instr_cnt performance counters.
module multicycle_control_unit #(
  parameter int MEM_WDT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       halt_cond,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       pc_source,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] state,
  output logic       is_halted,
  output logic       illegal_op,
`ifdef CTRL_PERF_CNT_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt,
`endif
  output logic       mem_fault
);
  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;
  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_HALT = 3'd5, S_FAULT = 3'd6
  } state_t;
  state_t cur, nxt;
  logic [7:0] wait_cnt;
  logic known, is_load, wdt_exp;
  // The branch decision is applied in the datapath as pc_write_cond & bcond.
  logic unused_bcond;
  assign unused_bcond = bcond;
  assign known = opcode inside {OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
                                OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL};
  assign is_load = opcode == OP_LOAD;
  assign wdt_exp = wait_cnt == 8'(MEM_WDT - 1);
  assign state = cur;
  assign is_halted = cur == S_HALT;
  assign mem_fault = cur == S_FAULT;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cur <= S_IF;
      wait_cnt <= '0;
    end else begin
      cur <= nxt;
      wait_cnt <= (nxt != cur || mem_ready) ? '0
                : (cur == S_IF || cur == S_MEM) ? wait_cnt + 8'd1 : '0;
    end
  always_comb begin
    nxt = cur;
    {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond} = '0;
    {reg_write, mem_to_reg, pc_source, alu_src_a, illegal_op} = '0;
    alu_op = 2'd0;
    alu_src_b = 2'd0;
    case (cur)
      S_IF: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
        alu_src_b = mem_ready ? 2'd1 : 2'd0;
        nxt = mem_ready ? S_ID : wdt_exp ? S_FAULT : S_IF;
      end
      S_ID: begin
        alu_src_b = 2'd2;
        illegal_op = !known;
        nxt = opcode == OP_ECALL ? (halt_cond ? S_HALT : S_IF) : known ? S_EX : S_IF;
      end
      S_EX: begin
        nxt = S_IF;
        case (opcode)
          OP_ARITH: begin
            alu_op = 2'd2;
            alu_src_a = 1'b1;
            nxt = S_WB;
          end
          OP_ARITH_IMM: begin
            alu_op = 2'd2;
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            nxt = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            nxt = S_MEM;
          end
          OP_BRANCH: begin
            alu_op = 2'd1;
            alu_src_a = 1'b1;
            pc_write_cond = 1'b1;
            pc_source = 1'b1;
          end
          OP_JAL, OP_JALR: begin
            pc_write = 1'b1;
            pc_source = 1'b1;
            nxt = S_WB;
          end
          default: nxt = S_IF;
        endcase
      end
      S_MEM: begin
        i_or_d = 1'b1;
        mem_read = is_load;
        mem_write = !is_load;
        nxt = mem_ready ? (is_load ? S_WB : S_IF) : wdt_exp ? S_FAULT : S_MEM;
      end
      S_WB: begin
        reg_write = 1'b1;
        mem_to_reg = is_load;
        nxt = S_IF;
      end
      default: nxt = cur;
    endcase
    // While reset is held the unit sits in a quiet fetch with no write pulses.
    if (!reset) begin
      {mem_write, i_or_d, ir_write, pc_write, pc_write_cond} = '0;
      {reg_write, mem_to_reg, pc_source, alu_src_a, illegal_op} = '0;
      alu_op = 2'd0;
      alu_src_b = 2'd0;
      mem_read = 1'b1;
    end
  end
`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (cur != S_HALT && cur != S_FAULT) cycle_cnt <= cycle_cnt + 32'd1;
      if (nxt == S_IF && cur inside {S_ID, S_EX, S_MEM, S_WB}) instr_cnt <= instr_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: table-driven cycle-by-cycle check of the control FSM
// plus hand sequences for reset, watchdog faults and the optional counters.
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic reset, bcond, halt_cond, mem_ready;
  logic [6:0] opcode;
  logic mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic reg_write, mem_to_reg, pc_source, alu_src_a, is_halted, illegal_op, mem_fault;
  logic [1:0] alu_op, alu_src_b;
  logic [2:0] state;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.MEM_WDT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond),
    .halt_cond(halt_cond), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .pc_source(pc_source),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .state(state), .is_halted(is_halted), .illegal_op(illegal_op),
`ifdef CTRL_PERF_CNT_EN
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
`endif
    .mem_fault(mem_fault)
  );

  localparam logic [6:0] ADD = 7'b0110011, ADDI = 7'b0010011, LD = 7'b0000011,
    ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111,
    ECALL = 7'b1110011, BAD = 7'b0000000;
  // {mr,mw,iod,irw,pcw,pcwc,rw,m2r,pcs,alu_op[1:0],src_a,src_b[1:0],ill,halt,fault}
  localparam logic [16:0]
    C_IFW = 17'b1_0_0_0_0_0_0_0_0_00_0_00_0_0_0,
    C_IFR = 17'b1_0_0_1_1_0_0_0_0_00_0_01_0_0_0,
    C_ID  = 17'b0_0_0_0_0_0_0_0_0_00_0_10_0_0_0,
    C_IDX = 17'b0_0_0_0_0_0_0_0_0_00_0_10_1_0_0,
    C_EXR = 17'b0_0_0_0_0_0_0_0_0_10_1_00_0_0_0,
    C_EXI = 17'b0_0_0_0_0_0_0_0_0_10_1_10_0_0_0,
    C_EXM = 17'b0_0_0_0_0_0_0_0_0_00_1_10_0_0_0,
    C_EXB = 17'b0_0_0_0_0_1_0_0_1_01_1_00_0_0_0,
    C_EXJ = 17'b0_0_0_0_1_0_0_0_1_00_0_00_0_0_0,
    C_MLD = 17'b1_0_1_0_0_0_0_0_0_00_0_00_0_0_0,
    C_MST = 17'b0_1_1_0_0_0_0_0_0_00_0_00_0_0_0,
    C_WBL = 17'b0_0_0_0_0_0_1_1_0_00_0_00_0_0_0,
    C_WB  = 17'b0_0_0_0_0_0_1_0_0_00_0_00_0_0_0,
    C_HLT = 17'b0_0_0_0_0_0_0_0_0_00_0_00_0_1_0,
    C_FLT = 17'b0_0_0_0_0_0_0_0_0_00_0_00_0_0_1;

  typedef struct {
    string n;
    logic [6:0] op;
    logic b, hc, rdy;
    logic [2:0] st;
    logic [16:0] c;
  } vec_t;
  vec_t vt[$];

  function automatic logic [16:0] ctl();
    return {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
            reg_write, mem_to_reg, pc_source, alu_op, alu_src_a, alu_src_b,
            illegal_op, is_halted, mem_fault};
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic row(string n, logic [6:0] op, logic b, logic hc, logic rdy,
                     logic [2:0] st, logic [16:0] c);
    vt.push_back('{n, op, b, hc, rdy, st, c});
  endtask

  task automatic step(int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(1);
    reset = 1'b1;
  endtask

  initial begin
    row("add_if", ADD, 0, 0, 1, 0, C_IFR);   row("add_id", ADD, 0, 0, 1, 1, C_ID);
    row("add_ex", ADD, 0, 0, 1, 2, C_EXR);   row("add_wb", ADD, 0, 0, 1, 4, C_WB);
    row("addi_if", ADDI, 0, 0, 1, 0, C_IFR); row("addi_id", ADDI, 0, 0, 1, 1, C_ID);
    row("addi_ex", ADDI, 0, 0, 1, 2, C_EXI); row("addi_wb", ADDI, 0, 0, 1, 4, C_WB);
    row("ld_if", LD, 0, 0, 1, 0, C_IFR);     row("ld_id", LD, 0, 0, 1, 1, C_ID);
    row("ld_ex", LD, 0, 0, 1, 2, C_EXM);
    for (int i = 0; i < 3; i++) row("ld_mem_wait", LD, 0, 0, 0, 3, C_MLD);
    row("ld_mem_rdy", LD, 0, 0, 1, 3, C_MLD); row("ld_wb", LD, 0, 0, 1, 4, C_WBL);
    row("st_if", ST, 0, 0, 1, 0, C_IFR);     row("st_id", ST, 0, 0, 1, 1, C_ID);
    row("st_ex", ST, 0, 0, 1, 2, C_EXM);     row("st_mem", ST, 0, 0, 1, 3, C_MST);
    row("br0_if", BR, 0, 0, 1, 0, C_IFR);    row("br0_id", BR, 0, 0, 1, 1, C_ID);
    row("br0_ex", BR, 0, 0, 1, 2, C_EXB);
    row("br1_if", BR, 1, 0, 1, 0, C_IFR);    row("br1_id", BR, 1, 0, 1, 1, C_ID);
    row("br1_ex", BR, 1, 0, 1, 2, C_EXB);
    row("jal_if", JAL, 0, 0, 1, 0, C_IFR);   row("jal_id", JAL, 0, 0, 1, 1, C_ID);
    row("jal_ex", JAL, 0, 0, 1, 2, C_EXJ);   row("jal_wb", JAL, 0, 0, 1, 4, C_WB);
    row("jalr_if", JALR, 0, 0, 1, 0, C_IFR); row("jalr_id", JALR, 0, 0, 1, 1, C_ID);
    row("jalr_ex", JALR, 0, 0, 1, 2, C_EXJ); row("jalr_wb", JALR, 0, 0, 1, 4, C_WB);
    row("bad_if", BAD, 0, 0, 1, 0, C_IFR);   row("bad_id", BAD, 0, 0, 1, 1, C_IDX);
    row("ec0_if", ECALL, 0, 0, 1, 0, C_IFR); row("ec0_id", ECALL, 0, 0, 1, 1, C_ID);
    for (int i = 0; i < 3; i++) row("wdt_if_wait", ECALL, 0, 1, 0, 0, C_IFW);
    row("wdt_if_rdy_on_expiry", ECALL, 0, 1, 1, 0, C_IFR);
    row("halt_id", ECALL, 0, 1, 1, 1, C_ID);
    row("halt0", ECALL, 0, 1, 1, 5, C_HLT);  row("halt1", ECALL, 0, 1, 1, 5, C_HLT);

    reset = 1'b0; opcode = ADD; bcond = 1'b0; halt_cond = 1'b0; mem_ready = 1'b1;
    #12;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_ctl", 32'(ctl()), 32'(C_IFW));
    reset = 1'b1;
    foreach (vt[i]) begin
      opcode = vt[i].op; bcond = vt[i].b; halt_cond = vt[i].hc; mem_ready = vt[i].rdy;
      #1;
      chk({vt[i].n, "_state"}, 32'(state), 32'(vt[i].st));
      chk({vt[i].n, "_ctl"}, 32'(ctl()), 32'(vt[i].c));
      step(1);
    end

    // Reset out of HALT, then first fetch starts on the first edge.
    reset = 1'b0;
    #1;
    chk("halt_reset_state", 32'(state), 32'd0);
    chk("halt_reset_ctl", 32'(ctl()), 32'(C_IFW));
    step(1);
    reset = 1'b1; opcode = ADD;
    #1;
    chk("post_reset_fetch", 32'(ctl()), 32'(C_IFR));
    step(1);
    chk("post_reset_id", 32'(state), 32'd1);

    // Watchdog expiry in IF with no handshake.
    do_reset();
    mem_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("wdt_if_cycle%0d", k), 32'(state), 32'd0);
      step(1);
    end
    chk("wdt_fault_state", 32'(state), 32'd6);
    chk("wdt_fault_ctl", 32'(ctl()), 32'(C_FLT));
    mem_ready = 1'b1;
    step(1);
    chk("fault_terminal", 32'(state), 32'd6);

    // Watchdog expiry in MEM during a store.
    do_reset();
    opcode = ST; mem_ready = 1'b1;
    step(3);
    mem_ready = 1'b0;
    step(4);
    chk("wdt_mem_fault", 32'(state), 32'd6);

    // Reset mid-store must kill mem_write immediately.
    do_reset();
    opcode = ST; mem_ready = 1'b1;
    step(3);
    mem_ready = 1'b0;
    #1;
    chk("st_stall_ctl", 32'(ctl()), 32'(C_MST));
    reset = 1'b0;
    #1;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_ctl", 32'(ctl()), 32'(C_IFW));
    step(1);
    chk("abort_hold_write", 32'(mem_write), 32'd0);
    reset = 1'b1;

`ifdef CTRL_PERF_CNT_EN
    do_reset();
    opcode = ADD; mem_ready = 1'b1;
    step(40);
    chk("instr_cnt", instr_cnt, 32'd10);
    chk("cycle_cnt", cycle_cnt, 32'd40);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
